// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default NOP, FSM state
// encodings and fetch error cause codes.
package ifu_fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // Reserved for a future CSR that records why a fetch failed.
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUSERR   = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fetch_cause_e;

endpackage

// File: rtl/ifu_line_buf.sv
// One-entry last-fetch buffer: holds a tag/data pair and reports a hit when
// the lookup address matches the stored tag.
module ifu_line_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              invalidate,
    input  logic [ADDR_W-1:0] load_tag,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load && !invalidate) begin
            tag_q  <= load_tag;
            data_q <= load_data;
        end
    end

    assign hit  = valid_q && (tag_q == lookup_addr);
    assign data = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues word fetches over a valid/ready request
// channel, waits for a variable-latency response and pulses the result.
module ifu_fetch #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned       TIMEOUT      = 255,
    parameter logic [DATA_W-1:0] NOP_INST     = ifu_fetch_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_req_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              fetch_err_o,
    output logic              busy_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i,
    input  logic              mem_resp_err_i
);

    import ifu_fetch_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] inst_d;
    logic              valid_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic              buf_load, buf_inval, buf_hit;
    logic [DATA_W-1:0] buf_data;

    ifu_line_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .invalidate  (buf_inval),
        .load_tag    (mem_req_addr_o),
        .load_data   (mem_resp_data_i),
        .lookup_addr (pc_i),
        .hit         (buf_hit),
        .data        (buf_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            inst_o         <= NOP_INST;
            inst_valid_o   <= 1'b0;
            fetch_err_o    <= 1'b0;
            mem_req_addr_o <= RESET_VECTOR;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            inst_o         <= inst_d;
            inst_valid_o   <= valid_d;
            fetch_err_o    <= err_d;
            mem_req_addr_o <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = inst_o;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        addr_d    = mem_req_addr_o;
        buf_load  = 1'b0;
        buf_inval = flush_i;
        unique case (state_q)
            ST_IDLE: begin
                // A request during an output pulse is dropped so pulses never touch.
                if (fetch_req_i && !flush_i && !inst_valid_o) begin
                    if (pc_i[1:0] != 2'b00) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (buf_hit) begin
                        inst_d  = buf_data;
                        valid_d = 1'b1;
                    end else begin
                        addr_d  = {pc_i[ADDR_W-1:2], 2'b00};
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (mem_req_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (flush_i) begin
                    // A response coincident with the flush is the one being discarded.
                    state_d = mem_resp_valid_i ? ST_IDLE : ST_DROP;
                end else if (mem_resp_valid_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    if (mem_resp_err_i) begin
                        inst_d    = NOP_INST;
                        err_d     = 1'b1;
                        buf_inval = 1'b1;
                    end else begin
                        inst_d   = mem_resp_data_i;
                        buf_load = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DROP;
                    inst_d  = NOP_INST;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_DROP: begin
                if (mem_resp_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req_valid_o = (state_q == ST_REQ);
    assign busy_o          = (state_q == ST_REQ) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and randomized checks of ifu_fetch against a transaction-level
// model of the last-fetch buffer and the fetch outcome rules.
module tb_ifu_fetch;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RV  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        fetch_req_i, flush_i;
    logic [31:0] inst_o;
    logic        inst_valid_o, fetch_err_o, busy_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        mem_resp_err_i;

    ifu_fetch #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .RESET_VECTOR (RV),
        .TIMEOUT      (TO),
        .NOP_INST     (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .fetch_req_i      (fetch_req_i),
        .flush_i          (flush_i),
        .inst_o           (inst_o),
        .inst_valid_o     (inst_valid_o),
        .fetch_err_o      (fetch_err_o),
        .busy_o           (busy_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model of the one-entry buffer.
    logic        mb_valid;
    logic [31:0] mb_tag, mb_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    task automatic do_fetch(input logic [31:0] addr, input int rdly, input int sdly, input logic berr);
        int          lat;
        logic [31:0] d;
        pc_i = addr;
        fetch_req_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        pc_i = $urandom();
        if (addr[1:0] != 2'b00) begin
            chk("mis_valid", inst_valid_o, 1);
            chk("mis_err", fetch_err_o, 1);
            chk("mis_inst", inst_o, NOP);
            chk("mis_noreq", mem_req_valid_o, 0);
        end else if (mb_valid && mb_tag == addr) begin
            chk("hit_valid", inst_valid_o, 1);
            chk("hit_inst", inst_o, mb_data);
            chk("hit_err", fetch_err_o, 0);
            chk("hit_noreq", mem_req_valid_o, 0);
        end else begin
            lat = 1;
            chk("req_valid", mem_req_valid_o, 1);
            chk("req_addr", mem_req_addr_o, addr);
            chk("req_busy", busy_o, 1);
            for (int i = 0; i < rdly; i++) begin
                tick();
                lat++;
                chk("stall_valid", mem_req_valid_o, 1);
                chk("stall_addr", mem_req_addr_o, addr);
            end
            mem_req_ready_i = 1'b1;
            tick();
            lat++;
            mem_req_ready_i = 1'b0;
            chk("wait_noreq", mem_req_valid_o, 0);
            chk("wait_busy", busy_o, 1);
            for (int i = 0; i < sdly; i++) begin
                tick();
                lat++;
                chk("wait_nopulse", inst_valid_o, 0);
            end
            d = mem_word(addr);
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = d;
            mem_resp_err_i   = berr;
            tick();
            lat++;
            mem_resp_valid_i = 1'b0;
            mem_resp_err_i   = 1'b0;
            mem_resp_data_i  = $urandom();
            chk("miss_valid", inst_valid_o, 1);
            chk("miss_err", fetch_err_o, {31'b0, berr});
            chk("miss_inst", inst_o, berr ? NOP : d);
            chk("miss_latency", lat, 3 + rdly + sdly);
            chk("miss_idle", busy_o, 0);
            if (berr) begin
                mb_valid = 1'b0;
            end else begin
                mb_valid = 1'b1;
                mb_tag   = addr;
                mb_data  = d;
            end
        end
        tick();
        chk("pulse_end", inst_valid_o, 0);
        chk("err_end", fetch_err_o, 0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        pc_i = '0;
        fetch_req_i = 1'b0;
        flush_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i = '0;
        mem_resp_err_i = 1'b0;
        mb_valid = 1'b0;
        mb_tag = '0;
        mb_data = '0;
        repeat (3) tick();
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_err", fetch_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_reqv", mem_req_valid_o, 0);
        chk("rst_addr", mem_req_addr_o, RV);
        rst = 1'b0;
        tick();

        // Basic miss, hit, next-word miss, misaligned pc.
        do_fetch(RV, 0, 0, 1'b0);
        do_fetch(RV, 0, 0, 1'b0);
        do_fetch(RV + 32'h4, 0, 0, 1'b0);
        do_fetch(RV + 32'h2, 0, 0, 1'b0);

        // Stalled request, bus error, then the re-fetch must miss.
        do_fetch(RV + 32'h8, 5, 1, 1'b1);
        do_fetch(RV + 32'h8, 0, 0, 1'b0);

        // Timeout, then a late response that must be swallowed.
        pc_i = RV + 32'h100;
        fetch_req_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        chk("to_req", mem_req_valid_o, 1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_early", inst_valid_o, 0);
        end
        tick();
        chk("to_valid", inst_valid_o, 1);
        chk("to_err", fetch_err_o, 1);
        chk("to_inst", inst_o, NOP);
        chk("to_notbusy", busy_o, 0);
        tick();
        chk("to_end", inst_valid_o, 0);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid_i = 1'b0;
        chk("late_drop", inst_valid_o, 0);
        tick();
        chk("late_drop2", inst_valid_o, 0);
        do_fetch(RV + 32'h104, 0, 2, 1'b0);

        // Flush in WAIT, response two cycles later is discarded; buffer invalid.
        do_fetch(RV + 32'h10, 0, 0, 1'b0);
        pc_i = RV + 32'h14;
        fetch_req_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mb_valid = 1'b0;
        chk("fl_wait_nopulse", inst_valid_o, 0);
        chk("fl_wait_busy", busy_o, 0);
        tick();
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        chk("fl_resp_drop", inst_valid_o, 0);
        tick();
        do_fetch(RV + 32'h10, 1, 0, 1'b0);

        // Flush coincident with the response: straight back to IDLE.
        pc_i = RV + 32'h18;
        fetch_req_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        mem_resp_valid_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mb_valid = 1'b0;
        chk("fl_coinc_nopulse", inst_valid_o, 0);
        do_fetch(RV + 32'h1C, 0, 0, 1'b0);

        // Flush in REQ retracts the request.
        pc_i = RV + 32'h20;
        fetch_req_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mb_valid = 1'b0;
        chk("fl_req_retract", mem_req_valid_o, 0);
        chk("fl_req_nopulse", inst_valid_o, 0);

        // Flush with a fetch in IDLE: the fetch is ignored.
        pc_i = RV + 32'h24;
        fetch_req_i = 1'b1;
        flush_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        flush_i = 1'b0;
        chk("fl_idle_noreq", mem_req_valid_o, 0);
        chk("fl_idle_nopulse", inst_valid_o, 0);
        tick();
        chk("fl_idle_noreq2", mem_req_valid_o, 0);

        // Reset during REQ; a stray response afterwards is ignored.
        pc_i = RV + 32'h28;
        fetch_req_i = 1'b1;
        tick();
        fetch_req_i = 1'b0;
        chk("rq_req", mem_req_valid_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mb_valid = 1'b0;
        chk("rq_reqv", mem_req_valid_o, 0);
        chk("rq_addr", mem_req_addr_o, RV);
        chk("rq_inst", inst_o, NOP);
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        chk("rq_stray", inst_valid_o, 0);
        tick();

        // Randomized fetch stream over a small address window.
        for (int n = 0; n < 40; n++) begin
            a = RV + 32'h40 + 32'($urandom_range(0, 3)) * 32'h4;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the rv32 core.
- Takes the core's pc and a fetch request, and fetches the 32-bit instruction over a valid/ready memory request channel with a variable-latency response channel.
- Delivers the instruction with a one-cycle valid pulse.
- Keeps a one-entry last-fetch buffer so repeated fetches of the same pc skip memory.
- Provides flush, misalignment error and response-timeout handling.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, instruction width
RESET_VECTOR, 32'h8000_0000, mem_req_addr_o value after reset
TIMEOUT, 255, WAIT cycles without a response before a fetch error is declared (must be ≥2)
NOP_INST, 32'h0000_0013, instruction driven on reset, error or timeout (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
pc_i  in  ADDR_W  fetch address from the core
fetch_req_i  in  1  single-cycle fetch request for pc_i
flush_i  in  1  abort the current fetch and invalidate the buffer
inst_o  out  DATA_W  fetched instruction, held between pulses
inst_valid_o  out  1  one-cycle pulse when inst_o is new
fetch_err_o  out  1  one-cycle pulse, coincident with inst_valid_o, on misaligned pc, memory error or timeout
busy_o  out  1  high in REQ and WAIT
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts the request
mem_req_addr_o  out  ADDR_W  request address, word aligned
mem_resp_valid_i  in  1  response valid
mem_resp_data_i  in  DATA_W  response data
mem_resp_err_i  in  1  response carries a bus error

Behaviour:
- Reset values:
  - state IDLE, inst_o=NOP_INST.
  - inst_valid_o, fetch_err_o, busy_o, mem_req_valid_o = 0.
  - mem_req_addr_o=RESET_VECTOR, buffer invalid, timeout counter 0.
- States: IDLE, REQ, WAIT, DROP.
- IDLE, fetch_req_i=1 and flush_i=0:
  - pc_i[1:0]≠0: next cycle inst_o=NOP_INST, inst_valid_o=1, fetch_err_o=1. No memory access. Stay IDLE.
  - Buffer valid and tag==pc_i (hit): next cycle inst_o=buffer data, inst_valid_o=1. Latency 1. Stay IDLE.
  - Otherwise (miss): latch pc_i into mem_req_addr_o, go to REQ.
- REQ:
  - mem_req_valid_o=1. mem_req_addr_o is stable until the handshake.
  - On mem_req_valid_o & mem_req_ready_i, go to WAIT and clear the counter.
  - mem_resp_valid_i is ignored in REQ. Memory responds no earlier than the cycle after acceptance.
- WAIT:
  - Counter increments every cycle.
  - On mem_resp_valid_i, next cycle inst_valid_o=1 and go to IDLE, then:
    - mem_resp_err_i=0: inst_o=data; buffer loads {tag=addr, data}, valid=1.
    - mem_resp_err_i=1: inst_o=NOP_INST, fetch_err_o=1; buffer invalidated.
  - Counter reaches TIMEOUT-1 with no response: next cycle NOP_INST, inst_valid_o=1, fetch_err_o=1; go to DROP.
- DROP: outstanding request. Discard the first mem_resp_valid_i, then go to IDLE. No output pulse.
- Minimum miss latency is 3 cycles (request sampled at E0, handshake at E1, response at E2, inst_valid_o high in cycle 3).
- flush_i (highest priority after rst). Always invalidates the buffer. Never produces inst_valid_o in the following cycle.
  - In IDLE: a coincident fetch_req_i is ignored.
  - In REQ: mem_req_valid_o is retracted next cycle (the only permitted retraction); go to IDLE.
  - In WAIT: go to DROP. A response arriving in the same cycle as flush_i counts as the discarded one; go to IDLE instead.
  - In DROP: no effect.
- fetch_req_i while busy_o=1 or in DROP is ignored. The core must not issue one.
- inst_valid_o and fetch_err_o are never high for two consecutive cycles.
- rst mid-operation returns everything to reset values. A later memory response arrives in IDLE and is ignored.
- Counter width: clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Add to the shared defines: NOP_INST, the state encodings (2-bit), and the fetch error cause codes (MISALIGN, BUSERR, TIMEOUT) for future CSR use.
- Sub-module ifu_line_buf holds the one-entry tag/data/valid buffer.
  - Inputs: load, invalidate, lookup address.
  - Outputs: hit, data.
  - Invalidate wins over load in the same cycle.

Test Plan:
1. Reset, then fetch pc 0x80000000 with ready=1 and response 0x00500093 one cycle after accept → inst_o=0x00500093, inst_valid_o high exactly in cycle 3, fetch_err_o=0.
2. Repeat the fetch of 0x80000000 → inst_valid_o the next cycle, mem_req_valid_o stays 0. Then fetch 0x80000004 → memory request issued.
3. Fetch pc 0x80000002 → next cycle inst_o=0x00000013, inst_valid_o=1, fetch_err_o=1, no memory request.
4. Hold mem_req_ready_i=0 for 5 cycles → addr stays stable and valid stays high. Then respond with mem_resp_err_i=1 → NOP, fetch_err_o=1, buffer invalid (a re-fetch misses).
5. Use TIMEOUT=4 with no response → error pulse 4 cycles after accept. A late response 3 cycles later is discarded (no pulse). The next fetch works normally.
6. Assert flush_i in WAIT, response 2 cycles later → no inst_valid_o. Assert flush_i and fetch_req_i together in IDLE → no request. Assert rst in REQ → mem_req_valid_o=0 and mem_req_addr_o=0x80000000 next cycle.
